// File: rtl/fifo_pkg.sv
// Shared constants and status/error bundles for the programmable-threshold synchronous FIFO.
package fifo_pkg;

   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
   } fifo_status_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Request/response bundle of sync_fifo_prog; the master drives requests and thresholds, the FIFO is the slave.
interface sync_fifo_prog_if
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int CW         = $clog2(DEF_FIFO_DEPTH + 1)
);
   logic [FIFO_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [CW-1:0]         af_thresh;
   logic [CW-1:0]         ae_thresh;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;
   logic [CW-1:0]         level;

   modport master (
      output data_in, wr_en, rd_en, af_thresh, ae_thresh,
      input  data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, level
   );

   modport slave (
      input  data_in, wr_en, rd_en, af_thresh, ae_thresh,
      output data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, level
   );
endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, combinational address-indexed read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [FIFO_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [FIFO_WIDTH-1:0] rdata_o
);
   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with runtime almost-full/almost-empty watermarks and occupancy level.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read-on-request.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input logic             clk,
   input logic             rst_n,
   sync_fifo_prog_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         wptr_q, rptr_q;
   logic [FIFO_WIDTH-1:0] dout_q, mem_rdata;
   logic                  wr_ack_q;
   fifo_err_t             err_q;
   fifo_status_t          status;
   logic                  wr_acc, rd_acc, mem_we;

   // Explicit wrap keeps non-power-of-two depths legal.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

`ifdef SYNC_FIFO_FWFT_EN
   logic          head_vld_q;
   logic [CW-1:0] mem_cnt;
   logic          head_load, bypass;

   // count_q includes the head register; the array only holds what sits behind it.
   assign mem_cnt   = count_q - CW'(head_vld_q);
   assign head_load = !head_vld_q || rd_acc;
   assign bypass    = head_load && (mem_cnt == '0) && wr_acc;
   assign mem_we    = wr_acc && !bypass;
`else
   assign mem_we    = wr_acc;
`endif

   always_comb begin
      status.full        = (count_q == DEPTH_C);
`ifdef SYNC_FIFO_FWFT_EN
      status.empty       = !head_vld_q;
`else
      status.empty       = (count_q == '0);
`endif
      status.almostfull  = (count_q >= bus.af_thresh);
      status.almostempty = (count_q <= bus.ae_thresh);
   end

   assign wr_acc = bus.wr_en && (!status.full || bus.rd_en);
   assign rd_acc = bus.rd_en && !status.empty;

   always_comb begin
      count_d = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   fifo_mem #(
      .FIFO_WIDTH(FIFO_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_mem (
      .clk    (clk),
      .we_i   (mem_we),
      .waddr_i(wptr_q),
      .wdata_i(bus.data_in),
      .raddr_i(rptr_q),
      .rdata_o(mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         dout_q   <= '0;
         wr_ack_q <= 1'b0;
         err_q    <= '0;
`ifdef SYNC_FIFO_FWFT_EN
         head_vld_q <= 1'b0;
`endif
      end else begin
         count_q         <= count_d;
         wr_ack_q        <= wr_acc;
         err_q.overflow  <= bus.wr_en && !wr_acc;
         err_q.underflow <= bus.rd_en && !rd_acc;
         if (mem_we) wptr_q <= ptr_inc(wptr_q);
`ifdef SYNC_FIFO_FWFT_EN
         // Refill the head from the array first; a write lands there directly only when the array is empty.
         if (head_load) begin
            if (mem_cnt != '0) begin
               dout_q     <= mem_rdata;
               rptr_q     <= ptr_inc(rptr_q);
               head_vld_q <= 1'b1;
            end else if (wr_acc) begin
               dout_q     <= bus.data_in;
               head_vld_q <= 1'b1;
            end else begin
               head_vld_q <= 1'b0;
            end
         end
`else
         if (rd_acc) begin
            dout_q <= mem_rdata;
            rptr_q <= ptr_inc(rptr_q);
         end
`endif
      end
   end

   assign bus.data_out    = dout_q;
   assign bus.wr_ack      = wr_ack_q;
   assign bus.overflow    = err_q.overflow;
   assign bus.underflow   = err_q.underflow;
   assign bus.full        = status.full;
   assign bus.empty       = status.empty;
   assign bus.almostfull  = status.almostfull;
   assign bus.almostempty = status.almostempty;
   assign bus.level       = count_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: depth-8 and depth-5 instances driven with directed vectors.
module tb_sync_fifo_prog;
   import fifo_pkg::*;

   typedef struct {
      logic [2:0]  p;      // {wr_ack, overflow, underflow}
      int          lvl;
      logic        chk_d;
      logic [15:0] d;
      int          af;
      int          ae;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t q8[$];
   exp_t q5[$];
   int   af8 = 6, ae8 = 2, af5 = 4, ae5 = 1;

   always #5 clk = ~clk;

   sync_fifo_prog_if #(.FIFO_WIDTH(16), .CW(4)) b8 ();
   sync_fifo_prog_if #(.FIFO_WIDTH(16), .CW(3)) b5 ();

   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_resp(input string tag, input exp_t e, input int depth,
                             input logic ack, input logic ovf, input logic unf,
                             input logic full, input logic empty, input logic af, input logic ae,
                             input logic [31:0] lvl, input logic [15:0] dout);
      chk({tag, ".wr_ack"},      {31'd0, ack}, {31'd0, e.p[2]});
      chk({tag, ".overflow"},    {31'd0, ovf}, {31'd0, e.p[1]});
      chk({tag, ".underflow"},   {31'd0, unf}, {31'd0, e.p[0]});
      chk({tag, ".ack_ovf_excl"}, {31'd0, ack & ovf}, 32'd0);
      chk({tag, ".level"},       lvl, e.lvl);
      chk({tag, ".full"},        {31'd0, full},  {31'd0, e.lvl == depth});
      chk({tag, ".empty"},       {31'd0, empty}, {31'd0, e.lvl == 0});
      chk({tag, ".almostfull"},  {31'd0, af},    {31'd0, e.lvl >= e.af});
      chk({tag, ".almostempty"}, {31'd0, ae},    {31'd0, e.lvl <= e.ae});
      if (e.chk_d) chk({tag, ".data_out"}, {16'd0, dout}, {16'd0, e.d});
   endtask

   // Monitors: one expected response per issued request cycle, compared after the edge.
   always @(negedge clk) begin
      if (q8.size() > 0) begin
         exp_t e;
         e = q8.pop_front();
         check_resp("d8", e, 8, b8.wr_ack, b8.overflow, b8.underflow, b8.full, b8.empty,
                    b8.almostfull, b8.almostempty, {28'd0, b8.level}, b8.data_out);
      end
   end

   always @(negedge clk) begin
      if (q5.size() > 0) begin
         exp_t e;
         e = q5.pop_front();
         check_resp("d5", e, 5, b5.wr_ack, b5.overflow, b5.underflow, b5.full, b5.empty,
                    b5.almostfull, b5.almostempty, {29'd0, b5.level}, b5.data_out);
      end
   end

   task automatic cyc8(input logic rst, input logic wr, input logic rd, input logic [15:0] din,
                       input logic [2:0] p, input int lvl, input logic chk_d, input logic [15:0] d);
      exp_t e;
      @(negedge clk);
      #1;
      rst_n        = !rst;
      b8.wr_en     = wr;
      b8.rd_en     = rd;
      b8.data_in   = din;
      b8.af_thresh = 4'(af8);
      b8.ae_thresh = 4'(ae8);
      e = '{p: p, lvl: lvl, chk_d: chk_d, d: d, af: af8, ae: ae8};
      q8.push_back(e);
   endtask

   task automatic cyc5(input logic wr, input logic rd, input logic [15:0] din,
                       input logic [2:0] p, input int lvl, input logic chk_d, input logic [15:0] d);
      exp_t e;
      @(negedge clk);
      #1;
      b5.wr_en     = wr;
      b5.rd_en     = rd;
      b5.data_in   = din;
      b5.af_thresh = 3'(af5);
      b5.ae_thresh = 3'(ae5);
      e = '{p: p, lvl: lvl, chk_d: chk_d, d: d, af: af5, ae: ae5};
      q5.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      b8.wr_en = 0; b8.rd_en = 0; b8.data_in = '0; b8.af_thresh = 4'd6; b8.ae_thresh = 4'd2;
      b5.wr_en = 0; b5.rd_en = 0; b5.data_in = '0; b5.af_thresh = 3'd4; b5.ae_thresh = 3'd1;

      // Reset, then idle
      cyc8(1, 0, 0, 16'h0, 3'b000, 0, 1, 16'h0000);
      cyc8(0, 0, 0, 16'h0, 3'b000, 0, 1, 16'h0000);

      // Fill 0x0001..0x0008
      for (int i = 1; i <= 8; i++) cyc8(0, 1, 0, 16'(i), 3'b100, i, 0, 16'h0);
      // Ninth write overflows
      cyc8(0, 1, 0, 16'h0009, 3'b010, 8, 0, 16'h0);
      // Full write with simultaneous read
      cyc8(0, 1, 1, 16'hAAAA, 3'b100, 8, 1, 16'h0001);
      // Drain
      for (int i = 2; i <= 8; i++) cyc8(0, 0, 1, 16'h0, 3'b000, 9 - i, 1, 16'(i));
      cyc8(0, 0, 1, 16'h0, 3'b000, 0, 1, 16'hAAAA);
      // Empty read with write: read rejected, write accepted, data_out holds
      cyc8(0, 1, 1, 16'h1234, 3'b101, 1, 1, 16'hAAAA);
      cyc8(0, 0, 1, 16'h0, 3'b000, 0, 1, 16'h1234);

      // Threshold corners: af=0 forces almostfull, ae>=depth forces almostempty
      af8 = 0; ae8 = 8;
      cyc8(0, 0, 0, 16'h0, 3'b000, 0, 1, 16'h1234);
      af8 = 15; ae8 = 0;
      cyc8(0, 1, 0, 16'h0077, 3'b100, 1, 1, 16'h1234);
      cyc8(0, 0, 1, 16'h0, 3'b000, 0, 1, 16'h0077);
      af8 = 6; ae8 = 2;

      // Mid-operation reset at level 4
      for (int i = 1; i <= 4; i++) cyc8(0, 1, 0, 16'(16'h10 + i), 3'b100, i, 0, 16'h0);
      cyc8(1, 0, 0, 16'h0, 3'b000, 0, 1, 16'h0000);
      cyc8(0, 0, 1, 16'h0, 3'b001, 0, 1, 16'h0000);
      cyc8(0, 0, 0, 16'h0, 3'b000, 0, 1, 16'h0000);

      // Depth 5: fill, stream across the wrap, drain
      for (int i = 0; i < 5; i++) cyc5(1, 0, 16'(16'h50 + i), 3'b100, i + 1, 0, 16'h0);
      for (int i = 0; i < 7; i++) cyc5(1, 1, 16'(16'h55 + i), 3'b100, 5, 1, 16'(16'h50 + i));
      for (int i = 0; i < 5; i++) cyc5(0, 1, 16'h0, 3'b000, 4 - i, 1, 16'(16'h57 + i));
      cyc5(0, 0, 16'h0, 3'b000, 0, 1, 16'h005B);

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q8.size() + q5.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
